// File: rtl/ad9364_rx_pattern_checker_pkg.sv
// Shared constants for the AD9364 square-wave pattern path.
// Class codes, FSM states, default levels, tolerance helper.
package ad9364_rx_pattern_checker_pkg;

    localparam logic [1:0] CLS_NONE = 2'b00;
    localparam logic [1:0] CLS_A    = 2'b01;
    localparam logic [1:0] CLS_B    = 2'b10;
    localparam logic [1:0] CLS_BAD  = 2'b11;

    // Levels also driven by the TX pattern generator.
    localparam logic [11:0] LVL_HI = 12'h7FF;
    localparam logic [11:0] LVL_LO = 12'h800;

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // |s - lvl| <= tol, both operands two's complement.
    // 13-bit difference cannot overflow; magnitude fits 13 bits.
    function automatic logic within_tol(
        input logic [11:0] s,
        input logic [11:0] lvl,
        input logic [11:0] tol
    );
        logic signed [12:0] d;
        logic        [12:0] mag;
        d   = $signed({s[11], s}) - $signed({lvl[11], lvl});
        mag = d[12] ? 13'(-d) : 13'(d);
        return (mag <= {1'b0, tol});
    endfunction

endpackage

// File: rtl/ad9364_sample_classifier.sv
// Stage 1: classify each valid I/Q sample as A, B or invalid.
// Ports: clk_i, rst_i, valid_i, i_i, q_i -> cls_o, cls_vld_o.
module ad9364_sample_classifier
    import ad9364_rx_pattern_checker_pkg::*;
#(
    parameter logic [11:0] LEVEL_A_I = LVL_HI,
    parameter logic [11:0] LEVEL_A_Q = LVL_HI,
    parameter logic [11:0] LEVEL_B_I = LVL_LO,
    parameter logic [11:0] LEVEL_B_Q = LVL_HI,
    parameter logic [11:0] TOLERANCE = 12'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [11:0] i_i,
    input  logic [11:0] q_i,
    output logic [1:0]  cls_o,
    output logic        cls_vld_o
);

    logic [1:0] cls_d, cls_q;
    logic       vld_q;
    logic       hit_a, hit_b;

    assign hit_a = within_tol(i_i, LEVEL_A_I, TOLERANCE)
                && within_tol(q_i, LEVEL_A_Q, TOLERANCE);
    assign hit_b = within_tol(i_i, LEVEL_B_I, TOLERANCE)
                && within_tol(q_i, LEVEL_B_Q, TOLERANCE);

    // A wins when the tolerance windows overlap.
    always_comb begin
        cls_d = CLS_BAD;
        if (hit_a)
            cls_d = CLS_A;
        else if (hit_b)
            cls_d = CLS_B;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cls_q <= CLS_NONE;
            vld_q <= 1'b0;
        end else begin
            vld_q <= valid_i;
            if (valid_i)
                cls_q <= cls_d;
        end
    end

    assign cls_o     = cls_q;
    assign cls_vld_o = vld_q;

endmodule

// File: rtl/ad9364_rx_pattern_checker.sv
// Stage 2: lock onto the A/B square wave, count errors/toggles.
// Ports: ADC sample stream in; lock, error and run statistics out.
module ad9364_rx_pattern_checker
    import ad9364_rx_pattern_checker_pkg::*;
#(
    parameter logic [11:0] LEVEL_A_I     = LVL_HI,
    parameter logic [11:0] LEVEL_A_Q     = LVL_HI,
    parameter logic [11:0] LEVEL_B_I     = LVL_LO,
    parameter logic [11:0] LEVEL_B_Q     = LVL_HI,
    parameter logic [11:0] TOLERANCE     = 12'd0,
    parameter int          LOCK_COUNT    = 16,
    parameter int          UNLOCK_ERRORS = 4,
    parameter int          RUN_W         = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adc_valid,
    input  logic [11:0]      adc_data_i1,
    input  logic [11:0]      adc_data_q1,
    input  logic             adc_status,
    input  logic             clr_counts,
    output logic             locked,
    output logic             err_pulse,
    output logic [31:0]      err_count,
    output logic [31:0]      toggle_count,
    output logic [RUN_W-1:0] last_run_len,
    output logic [1:0]       sample_class
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int CW = $clog2(UNLOCK_ERRORS + 1);

    logic [1:0] cls;
    logic       cls_vld;

    ad9364_sample_classifier #(
        .LEVEL_A_I (LEVEL_A_I),
        .LEVEL_A_Q (LEVEL_A_Q),
        .LEVEL_B_I (LEVEL_B_I),
        .LEVEL_B_Q (LEVEL_B_Q),
        .TOLERANCE (TOLERANCE)
    ) u_cls (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (adc_valid),
        .i_i       (adc_data_i1),
        .q_i       (adc_data_q1),
        .cls_o     (cls),
        .cls_vld_o (cls_vld)
    );

    state_e           state_q, state_d;
    logic [GW-1:0]    good_q, good_d;
    logic [CW-1:0]    consec_q, consec_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [RUN_W-1:0] last_q, last_d;
    logic [1:0]       prev_q, prev_d;
    logic [1:0]       scls_q, scls_d;
    logic [31:0]      err_q, err_d;
    logic [31:0]      tog_q, tog_d;
    logic             pulse_q, pulse_d;
    logic             is_bad, lock_hit, unlock_hit;

    assign is_bad     = (cls == CLS_BAD);
    assign lock_hit   = (good_q == GW'(LOCK_COUNT - 1));
    assign unlock_hit = (consec_q == CW'(UNLOCK_ERRORS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_SEARCH;
            good_q   <= '0;
            consec_q <= '0;
            run_q    <= '0;
            last_q   <= '0;
            prev_q   <= CLS_NONE;
            scls_q   <= CLS_NONE;
            err_q    <= '0;
            tog_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            consec_q <= consec_d;
            run_q    <= run_d;
            last_q   <= last_d;
            prev_q   <= prev_d;
            scls_q   <= scls_d;
            err_q    <= err_d;
            tog_q    <= tog_d;
            pulse_q  <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!adc_status) begin
            state_d = ST_SEARCH;
        end else if (cls_vld) begin
            unique case (state_q)
                ST_SEARCH:
                    if (!is_bad && lock_hit)
                        state_d = ST_LOCKED;
                ST_LOCKED:
                    if (is_bad && unlock_hit)
                        state_d = ST_SEARCH;
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    always_comb begin
        good_d   = good_q;
        consec_d = consec_q;
        run_d    = run_q;
        last_d   = last_q;
        prev_d   = prev_q;
        scls_d   = scls_q;
        err_d    = err_q;
        tog_d    = tog_q;
        pulse_d  = 1'b0;
        if (!adc_status) begin
            // Link down: restart acquisition, keep statistics.
            good_d   = '0;
            run_d    = '0;
            consec_d = '0;
        end else if (cls_vld) begin
            scls_d = cls;
            unique case (state_q)
                ST_SEARCH: begin
                    if (is_bad) begin
                        good_d = '0;
                    end else if (lock_hit) begin
                        good_d   = '0;
                        run_d    = RUN_W'(1);
                        prev_d   = cls;
                        consec_d = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (is_bad) begin
                        // Run and previous class survive errors.
                        pulse_d = 1'b1;
                        if (err_q != '1)
                            err_d = err_q + 1'b1;
                        if (unlock_hit) begin
                            consec_d = '0;
                            good_d   = '0;
                        end else begin
                            consec_d = consec_q + 1'b1;
                        end
                    end else begin
                        consec_d = '0;
                        if (cls == prev_q) begin
                            if (run_q != '1)
                                run_d = run_q + 1'b1;
                        end else begin
                            last_d = run_q;
                            run_d  = RUN_W'(1);
                            tog_d  = tog_q + 1'b1;
                            prev_d = cls;
                        end
                    end
                end
                default: good_d = '0;
            endcase
        end
        if (clr_counts) begin
            err_d  = '0;
            tog_d  = '0;
            last_d = '0;
        end
    end

    assign locked       = (state_q == ST_LOCKED);
    assign err_pulse    = pulse_q;
    assign err_count    = err_q;
    assign toggle_count = tog_q;
    assign last_run_len = last_q;
    assign sample_class = scls_q;

endmodule

// File: tb/tb_ad9364_rx_pattern_checker.sv
// Directed scoreboard bench for ad9364_rx_pattern_checker.
// Two instances share stimulus: TOLERANCE 0 (main) and 4.
module tb_ad9364_rx_pattern_checker;

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_A    = 2'b01;
    localparam logic [1:0] C_B    = 2'b10;
    localparam logic [1:0] C_BAD  = 2'b11;
    localparam logic [11:0] AI = 12'h7FF;
    localparam logic [11:0] AQ = 12'h7FF;
    localparam logic [11:0] BI = 12'h800;
    localparam logic [11:0] BQ = 12'h7FF;

    logic        clk = 1'b0;
    logic        rst;
    logic        adc_valid;
    logic [11:0] adc_data_i1;
    logic [11:0] adc_data_q1;
    logic        adc_status;
    logic        clr_counts;

    logic        locked, err_pulse;
    logic [31:0] err_count, toggle_count;
    logic [9:0]  last_run_len;
    logic [1:0]  sample_class;

    logic        locked4, err_pulse4;
    logic [31:0] err_count4, toggle_count4;
    logic [9:0]  last_run_len4;
    logic [1:0]  sample_class4;

    ad9364_rx_pattern_checker dut (
        .clk          (clk),
        .rst          (rst),
        .adc_valid    (adc_valid),
        .adc_data_i1  (adc_data_i1),
        .adc_data_q1  (adc_data_q1),
        .adc_status   (adc_status),
        .clr_counts   (clr_counts),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .toggle_count (toggle_count),
        .last_run_len (last_run_len),
        .sample_class (sample_class)
    );

    ad9364_rx_pattern_checker #(.TOLERANCE(12'd4)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .adc_valid    (adc_valid),
        .adc_data_i1  (adc_data_i1),
        .adc_data_q1  (adc_data_q1),
        .adc_status   (adc_status),
        .clr_counts   (clr_counts),
        .locked       (locked4),
        .err_pulse    (err_pulse4),
        .err_count    (err_count4),
        .toggle_count (toggle_count4),
        .last_run_len (last_run_len4),
        .sample_class (sample_class4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lk;
        logic        pulse;
        logic [31:0] err;
        logic [31:0] tog;
        logic [9:0]  last;
        logic [1:0]  cls;
        logic [1:0]  cls4;
    } exp_t;

    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;

    // Reference model state
    bit          m_lk;
    int          m_good, m_run, m_consec;
    logic [1:0]  m_prev, m_cls;
    bit          m_pulse;
    logic [31:0] m_err, m_tog;
    int          m_last;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input logic [11:0] v);
        return v[11] ? int'(v) - 4096 : int'(v);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [1:0] classify(input logic [11:0] i,
                                            input logic [11:0] q,
                                            input int tol);
        if (iabs(sx(i) - sx(AI)) <= tol && iabs(sx(q) - sx(AQ)) <= tol)
            return C_A;
        if (iabs(sx(i) - sx(BI)) <= tol && iabs(sx(q) - sx(BQ)) <= tol)
            return C_B;
        return C_BAD;
    endfunction

    task automatic model_reset();
        m_lk = 0; m_good = 0; m_run = 0; m_consec = 0;
        m_prev = C_NONE; m_cls = C_NONE; m_pulse = 0;
        m_err = 0; m_tog = 0; m_last = 0;
    endtask

    task automatic model_step(input logic [1:0] c, input bit clr);
        m_pulse = 0;
        m_cls   = c;
        if (!m_lk) begin
            if (c == C_BAD) m_good = 0;
            else begin
                m_good++;
                if (m_good == 16) begin
                    m_lk = 1; m_good = 0; m_run = 1;
                    m_prev = c; m_consec = 0;
                end
            end
        end else if (c == C_BAD) begin
            m_pulse = 1;
            if (m_err != 32'hFFFF_FFFF) m_err++;
            m_consec++;
            if (m_consec == 4) begin
                m_lk = 0; m_good = 0; m_consec = 0;
            end
        end else begin
            m_consec = 0;
            if (c == m_prev) begin
                if (m_run < 1023) m_run++;
            end else begin
                m_last = m_run; m_run = 1; m_tog++; m_prev = c;
            end
        end
        if (clr) begin
            m_err = 0; m_tog = 0; m_last = 0;
        end
    endtask

    function automatic exp_t snap(input logic [1:0] c4);
        exp_t e;
        e.lk = m_lk; e.pulse = m_pulse; e.err = m_err; e.tog = m_tog;
        e.last = 10'(m_last); e.cls = m_cls; e.cls4 = c4;
        return e;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, ".locked"}, 32'(locked), 32'(e.lk));
        chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(e.pulse));
        chk({tag, ".err_count"}, err_count, e.err);
        chk({tag, ".toggle_count"}, toggle_count, e.tog);
        chk({tag, ".last_run_len"}, 32'(last_run_len), 32'(e.last));
        chk({tag, ".sample_class"}, 32'(sample_class), 32'(e.cls));
    endtask

    // One sample, valid every other clock; outputs checked 2 clk later.
    task automatic send(input string tag, input logic [11:0] i,
                        input logic [11:0] q, input bit clr = 1'b0);
        exp_t e;
        adc_valid   = 1'b1;
        adc_data_i1 = i;
        adc_data_q1 = q;
        model_step(classify(i, q, 0), clr);
        sb.push_back(snap(classify(i, q, 4)));
        @(posedge clk); #1;
        adc_valid  = 1'b0;
        clr_counts = clr;
        @(posedge clk); #1;
        clr_counts = 1'b0;
        e = sb.pop_front();
        check_outputs(tag, e);
        chk({tag, ".sample_class_tol4"}, 32'(sample_class4), 32'(e.cls4));
        if (err_pulse === 1'b1) pulses++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        adc_valid = 1'b0;
        adc_data_i1 = '0;
        adc_data_q1 = '0;
        adc_status = 1'b1;
        clr_counts = 1'b0;
        model_reset();
        #2;
        check_outputs("reset", snap(C_NONE));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Alternating 32-sample runs A,B,A,B
        for (int blk = 0; blk < 4; blk++) begin
            for (int n = 0; n < 32; n++) begin
                if (blk[0]) send("alt", BI, BQ);
                else        send("alt", AI, AQ);
                if (blk == 0 && n == 14) chk("prelock", 32'(locked), 0);
                if (blk == 0 && n == 15) chk("lock16", 32'(locked), 1);
            end
        end
        chk("run32", 32'(last_run_len), 32);
        chk("tog3", toggle_count, 3);

        // Three errors then a good sample
        pulses = 0;
        for (int n = 0; n < 3; n++) send("err3", 12'h000, 12'h7FF);
        send("err3_good", AI, AQ);
        chk("err3_pulses", 32'(pulses), 3);
        chk("err3_count", err_count, 3);
        chk("err3_locked", 32'(locked), 1);

        // Four consecutive errors drop lock
        send("clr", AI, AQ, 1'b1);
        for (int n = 0; n < 4; n++) begin
            send("err4", 12'h000, 12'h7FF);
            if (n == 2) chk("err4_still", 32'(locked), 1);
        end
        chk("err4_unlock", 32'(locked), 0);
        chk("err4_count", err_count, 4);
        send("err4_hold", AI, AQ);
        chk("err4_hold_count", err_count, 4);
        for (int n = 0; n < 15; n++) send("relock", BI, BQ);
        chk("relock", 32'(locked), 1);

        // Tolerance window (second instance has TOLERANCE=4)
        send("tol_in", 12'h7FC, 12'h7FF);
        chk("tol_in_A", 32'(sample_class4), 32'(C_A));
        chk("tol_in_strict", 32'(sample_class), 32'(C_BAD));
        send("tol_out", 12'h7FA, 12'h7FF);
        chk("tol_out_bad", 32'(sample_class4), 32'(C_BAD));
        send("tol_good", AI, AQ);

        // Interface status drop for one clock
        adc_status = 1'b0;
        @(posedge clk); #1;
        adc_status = 1'b1;
        m_lk = 0; m_good = 0; m_run = 0; m_consec = 0; m_pulse = 0;
        check_outputs("status", snap(C_NONE));
        for (int n = 0; n < 16; n++) send("relock2", AI, AQ);
        chk("relock2", 32'(locked), 1);

        // Clear in the same cycle as an error increment
        send("clr_err", 12'h000, 12'h7FF, 1'b1);
        chk("clr_err_count", err_count, 0);
        send("e7", AI, AQ);
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 3; n++) send("e7", 12'h000, 12'h7FF);
            send("e7", AI, AQ);
        end
        send("e7", 12'h000, 12'h7FF);
        chk("err7", err_count, 7);

        // Asynchronous reset mid-transfer
        adc_valid   = 1'b1;
        adc_data_i1 = AI;
        adc_data_q1 = AQ;
        @(posedge clk); #1;
        adc_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst", snap(C_NONE));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int n = 0; n < 15; n++) send("post_rst", AI, AQ);
        chk("post_rst_nolock", 32'(locked), 0);
        send("post_rst", AI, AQ);
        chk("post_rst_lock", 32'(locked), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
